rs232_rx_fifo: RTL and testbench
================================

# rs232_rx_fifo

Receive buffer between the serial receiver (RS232R) and the processor I/O bus. It drains received bytes from the receiver as soon as they are ready and holds up to DEPTH of them. The CPU can then fall behind the line rate by up to DEPTH bytes without losing characters. The top level maps `data` to the RS-232 data register and `rdy`/`ovf`/`count` into the status register.

## Interface
- `DEPTH`, default 16: number of byte slots; power of two, minimum 2.
- `AW`, default 4: log2(DEPTH); pointer width.

Ports:
- `clk` — in, 1: single clock for the whole block.
- `rst` — in, 1: reset, asynchronous, active-low. One clock domain; no other clock enters the block.
- `rdyRx` — in, 1: byte available from the receiver. Level signal; falls one cycle after `doneRx`.
- `dataRx` — in, 8: received byte, valid while `rdyRx` = 1.
- `doneRx` — out, 1: registered one-cycle pulse that acknowledges and consumes the receiver byte.
- `rd` — in, 1: CPU read strobe of the data register (`rd & ioenb & iowadr==2`).
- `clr` — in, 1: flush strobe. Empties the buffer and clears `ovf`.
- `data` — out, 8: byte at the head of the buffer.
- `rdy` — out, 1: buffer not empty.
- `count` — out, AW+1: number of bytes held, range 0..DEPTH.
- `ovf` — out, 1: sticky overflow flag.

## Operation
- **Storage:** DEPTH×8 memory with write pointer `wp` and read pointer `rp`, both AW bits wide and wrapping modulo DEPTH. An (AW+1)-bit counter `cnt` drives `count`. `full` is `cnt==DEPTH`; `rdy` is `cnt!=0`.
- **Capture condition:** `take = rdyRx & ~doneRx`. The `~doneRx` term blocks a second capture during the cycle in which the receiver is still clearing its `rdy`.
- **On `take`:**
  - `doneRx` is 1 in the following cycle.
  - If `~full | rd_eff`: write `dataRx` to `mem[wp]` and advance `wp`.
  - Otherwise the byte is dropped (still acknowledged) and `ovf` is set to 1.
- **Read:** `rd_eff = rd & rdy`. On `rd_eff`, `rp` advances. `rd` while empty is ignored and the pointers do not move.
- **Head output:** `data = mem[rp]`. It is combinational from the registered pointer and is stale while empty.
- **Counter update:**
  - `cnt` += 1 on write only.
  - `cnt` −= 1 on `rd_eff` only.
  - Unchanged when both happen in the same cycle.
- **Flush:** `clr` has priority over everything. `wp`, `rp`, `cnt` and `ovf` go to 0. A `take` in the same cycle is still acknowledged, and its byte is discarded.
- **Overflow flag:** `ovf` is cleared only by reset or `clr`.

## Timing
- **Reset values:** `doneRx`=0, `rdy`=0, `count`=0, `ovf`=0, `wp`=`rp`=0. Memory contents are not reset and `data` is undefined until the first write.
- **Write latency:** `rdyRx` rising at cycle n gives capture at the edge ending n. At n+1, `rdy`=1, `count`=1, `data` is valid and `doneRx`=1.
- **Receiver handshake:** `rdyRx` falls at n+2. The earliest next capture is when `rdyRx` next rises.
- **Read latency:** `rd` at cycle n advances `rp`. The next byte appears on `data` at n+1. The CPU samples `data` in the same cycle as `rd`.
- **Full with read in the same cycle:** write and read both occur, `count` stays at DEPTH and `ovf` stays 0.
- **Wrap-around:** pointers roll from DEPTH−1 to 0 with no bubble.
- **Reset during a handshake:** `doneRx` is forced to 0 immediately. A byte still pending in the receiver is captured normally after reset is released.

## Structure
- **Shared package:** I/O word addresses (data=2, status=3) and the status-word bit positions for `rdy`, `ovf` and `count`.
- **Sub-module:** `fifo_sync`, a generic single-clock FIFO (parameters W, DEPTH; write/read strobes; full/empty/count). Build it as a sub-module so the transmit side can reuse it. `rs232_rx_fifo` adds the receiver handshake, overflow drop and flush around it.

## Test plan
- **Single byte:** drive `rdyRx`=1 with `dataRx`=0x41 for 2 cycles and release. Expect exactly one `doneRx` pulse, `rdy`=1 and `count`=1 at n+1, and `data`=0x41. Then `rd` → `rdy`=0 and `count`=0 one cycle later.
- **Order and wrap:** push 0x00..0x17 in three batches of 8, with reads interleaved after each batch. Expect bytes to read back in order across the pointer wrap, with `ovf`=0 throughout.
- **Overflow:** push 17 bytes 0x10..0x20 with no reads. Expect `count`=16, `ovf`=1, 17 `doneRx` pulses, reads returning 0x10..0x1F, and 0x20 lost.
- **Simultaneous read and write when full:** with the buffer full, assert `take` and `rd` in the same cycle. Expect `count` to stay 16, `ovf`=0, and the new byte read out last.
- **Flush:** with `count`=5 and `ovf`=1, pulse `clr`. Expect `count`=0, `rdy`=0 and `ovf`=0 next cycle. `rd` while empty leaves `count`=0.
- **Async reset:** assert `rst`=0 mid-handshake, away from any clock edge. Expect all outputs at their reset values without waiting for a clock edge, then normal capture after release.

Source files
------------

// File: rtl/rs232_rx_fifo_pkg.sv
// Shared definitions for the RS-232 receive path: byte width, I/O word
// addresses and the layout of the status word.
package rs232_rx_fifo_pkg;

   localparam int BYTE_W = 8;

   localparam logic [3:0] IO_ADDR_DATA   = 4'd2;
   localparam logic [3:0] IO_ADDR_STATUS = 4'd3;

   localparam int STAT_RDY_BIT = 0;
   localparam int STAT_OVF_BIT = 1;
   localparam int STAT_CNT_LSB = 2;

endpackage

// File: rtl/rs232_rx_fifo_fifo_sync.sv
// Generic single-clock FIFO. A write is accepted when not full, or when a
// read retires the head in the same cycle. A read while empty is ignored.
// clr empties the FIFO and overrides both strobes.
module fifo_sync #(
   parameter int W     = 8,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          wr,
   input  logic [W-1:0]  wdata,
   input  logic          rd,
   output logic [W-1:0]  rdata,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wp_q, wp_d;
   logic [AW-1:0] rp_q, rp_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          rd_ok;
   logic          wr_ok;

   assign full  = (cnt_q == FULL_CNT);
   assign empty = (cnt_q == '0);
   assign count = cnt_q;
   assign rdata = mem_q[rp_q];

   // Next-state for pointers and occupancy; clr has priority.
   always_comb begin
      rd_ok = rd & ~empty;
      wr_ok = wr & (~full | rd_ok);
      wp_d  = wp_q;
      rp_d  = rp_q;
      cnt_d = cnt_q;
      if (clr) begin
         wp_d  = '0;
         rp_d  = '0;
         cnt_d = '0;
      end else begin
         if (wr_ok) wp_d = wp_q + 1'b1;
         if (rd_ok) rp_d = rp_q + 1'b1;
         case ({wr_ok, rd_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   // Pointer and counter registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         cnt_q <= cnt_d;
      end
   end

   // Storage array; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_ok && !clr) mem_q[wp_q] <= wdata;
   end

endmodule

// File: rtl/rs232_rx_fifo.sv
// Receive buffer between the serial receiver and the CPU I/O bus. Captures
// each byte the receiver offers, acknowledges it with a one-cycle doneRx
// pulse, and drops (but still acknowledges) bytes that arrive while full.
module rs232_rx_fifo
   import rs232_rx_fifo_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdyRx,
   input  logic [BYTE_W-1:0] dataRx,
   output logic              doneRx,
   input  logic              rd,
   input  logic              clr,
   output logic [BYTE_W-1:0] data,
   output logic              rdy,
   output logic [AW:0]       count,
   output logic              ovf
);

   logic done_q, done_d;
   logic ovf_q, ovf_d;
   logic take;
   logic rd_eff;
   logic drop;
   logic fifo_full;
   logic fifo_empty;

   fifo_sync #(
      .W     (BYTE_W),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .wr    (take),
      .wdata (dataRx),
      .rd    (rd),
      .rdata (data),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (count)
   );

   // The ~done_q term keeps us from re-capturing while the receiver is
   // still lowering rdyRx after our acknowledge.
   always_comb begin
      take   = rdyRx & ~done_q;
      rd_eff = rd & ~fifo_empty;
      drop   = take & fifo_full & ~rd_eff;
      done_d = take;
      ovf_d  = clr ? 1'b0 : (ovf_q | drop);
   end

   // Acknowledge pulse and sticky overflow flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         done_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         done_q <= done_d;
         ovf_q  <= ovf_d;
      end
   end

   assign doneRx = done_q;
   assign ovf    = ovf_q;
   assign rdy    = ~fifo_empty;

endmodule

// File: tb/tb_rs232_rx_fifo.sv
// Self-checking bench for rs232_rx_fifo: directed scenarios followed by a
// randomized mix, all compared against a queue-based model of the buffer.
module tb_rs232_rx_fifo;

   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic          clk;
   logic          rst;
   logic          rdyRx;
   logic [7:0]    dataRx;
   logic          doneRx;
   logic          rd;
   logic          clr;
   logic [7:0]    data;
   logic          rdy;
   logic [AW:0]   count;
   logic          ovf;

   int n_chk;
   int n_fail;

   logic [7:0] q[$];
   bit         m_ovf;
   int         exp_done;
   int         done_pulses;
   logic       done_prev;

   rs232_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk    (clk),
      .rst    (rst),
      .rdyRx  (rdyRx),
      .dataRx (dataRx),
      .doneRx (doneRx),
      .rd     (rd),
      .clr    (clr),
      .data   (data),
      .rdy    (rdy),
      .count  (count),
      .ovf    (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count rising edges of the acknowledge, sampled mid-cycle.
   initial begin
      done_pulses = 0;
      done_prev   = 1'b0;
      forever begin
         @(negedge clk);
         if (doneRx === 1'b1 && done_prev !== 1'b1) done_pulses++;
         done_prev = doneRx;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_state();
      chk("count", 32'(count), 32'(q.size()));
      chk("rdy", 32'(rdy), 32'(q.size() != 0));
      chk("ovf", 32'(ovf), 32'(m_ovf));
      if (q.size() != 0) chk("head", 32'(data), 32'(q[0]));
   endtask

   // One bus/receiver transaction starting right after a negedge.
   task automatic do_cycle(input bit tx, input logic [7:0] b, input bit r, input bit c);
      bit rde;
      bit was_full;
      if (r && q.size() != 0) chk("head_at_rd", 32'(data), 32'(q[0]));
      rdyRx  = tx;
      dataRx = b;
      rd     = r;
      clr    = c;
      @(negedge clk);
      rd  = 1'b0;
      clr = 1'b0;
      if (c) begin
         q.delete();
         m_ovf = 1'b0;
      end else begin
         rde      = r && (q.size() != 0);
         was_full = (q.size() == DEPTH);
         if (rde) void'(q.pop_front());
         if (tx) begin
            if (!was_full || rde) q.push_back(b);
            else m_ovf = 1'b1;
         end
      end
      if (tx) begin
         exp_done++;
         chk("done_pulse", 32'(doneRx), 32'd1);
         @(negedge clk);
         rdyRx = 1'b0;
         chk("done_single", 32'(doneRx), 32'd0);
      end
      check_state();
   endtask

   task automatic push(input logic [7:0] b);
      do_cycle(1'b1, b, 1'b0, 1'b0);
   endtask

   task automatic pop();
      do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
   endtask

   initial begin
      int sel;
      n_chk    = 0;
      n_fail   = 0;
      m_ovf    = 1'b0;
      exp_done = 0;
      rst      = 1'b0;
      rdyRx    = 1'b0;
      dataRx   = 8'h00;
      rd       = 1'b0;
      clr      = 1'b0;

      repeat (2) @(negedge clk);
      chk("rst_done", 32'(doneRx), 32'd0);
      chk("rst_rdy", 32'(rdy), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      rst = 1'b1;
      @(negedge clk);

      // Single byte, then read it back.
      push(8'h41);
      chk("single_data", 32'(data), 32'h41);
      pop();
      chk("single_empty_count", 32'(count), 32'd0);

      // Order across the pointer wrap.
      for (int bt = 0; bt < 3; bt++) begin
         for (int i = 0; i < 8; i++) push(8'(bt * 8 + i));
         for (int i = 0; i < 8; i++) pop();
      end

      // Overflow: 17 bytes into 16 slots, the last one lost.
      for (int i = 0; i < 17; i++) push(8'(8'h10 + i));
      chk("ovf_count", 32'(count), 32'd16);
      chk("ovf_flag", 32'(ovf), 32'd1);
      for (int i = 0; i < 16; i++) begin
         chk("ovf_order", 32'(data), 32'(8'h10 + i));
         pop();
      end
      chk("ovf_drained", 32'(rdy), 32'd0);

      // Full with a read in the same cycle as the capture.
      do_cycle(1'b0, 8'h00, 1'b0, 1'b1);
      for (int i = 0; i < 16; i++) push(8'(8'h80 + i));
      do_cycle(1'b1, 8'hAA, 1'b1, 1'b0);
      chk("full_rw_count", 32'(count), 32'd16);
      chk("full_rw_ovf", 32'(ovf), 32'd0);
      for (int i = 0; i < 15; i++) pop();
      chk("full_rw_last", 32'(data), 32'hAA);
      pop();

      // Flush with count=5 and ovf set, then read while empty.
      for (int i = 0; i < 17; i++) push(8'(8'h30 + i));
      for (int i = 0; i < 11; i++) pop();
      chk("pre_flush_count", 32'(count), 32'd5);
      chk("pre_flush_ovf", 32'(ovf), 32'd1);
      do_cycle(1'b0, 8'h00, 1'b0, 1'b1);
      chk("flush_count", 32'(count), 32'd0);
      chk("flush_ovf", 32'(ovf), 32'd0);
      pop();
      chk("empty_rd_count", 32'(count), 32'd0);

      // Flush with a capture in the same cycle: acknowledged, discarded.
      push(8'h01);
      do_cycle(1'b1, 8'h55, 1'b0, 1'b1);
      chk("flush_take_count", 32'(count), 32'd0);

      // Asynchronous reset in the middle of a handshake.
      push(8'h02);
      rdyRx  = 1'b1;
      dataRx = 8'h5A;
      @(negedge clk);
      chk("hs_done", 32'(doneRx), 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("arst_done", 32'(doneRx), 32'd0);
      chk("arst_rdy", 32'(rdy), 32'd0);
      chk("arst_count", 32'(count), 32'd0);
      chk("arst_ovf", 32'(ovf), 32'd0);
      q.delete();
      m_ovf = 1'b0;
      exp_done++;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst_done", 32'(doneRx), 32'd1);
      q.push_back(8'h5A);
      exp_done++;
      @(negedge clk);
      rdyRx = 1'b0;
      check_state();

      // Randomized mix of captures, reads, simultaneous and flushes.
      for (int it = 0; it < 500; it++) begin
         sel = $urandom_range(0, 99);
         if (sel < 45)      do_cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
         else if (sel < 80) do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
         else if (sel < 95) do_cycle(1'b1, 8'($urandom), 1'b1, 1'b0);
         else               do_cycle(1'($urandom), 8'($urandom), 1'($urandom), 1'b1);
      end

      @(negedge clk);
      chk("done_pulses", 32'(done_pulses), 32'(exp_done));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
